mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//  Sits between the I-cache/D-cache pair and the shared pipelined main memory.
//  Arbitrates I-cache misses, D-cache misses and D-cache write-through stores.
//  Refills one block per miss: issues WORDS reads back-to-back, steers each returned word into the missing cache.
//  Drives the CPU-wide stall while any memory transaction is pending.
// PARAMETERS
//  ADDR_W   16  byte address width
//  DATA_W   16  word width
//  WORDS    8   words per cache block (power of 2); block = 2*WORDS bytes
//  MEM_LAT  4   cycles from read issue to mem_data_valid
// PORTS
//  clk               in   1       system clock, rising edge
//  rst_n             in   1       asynchronous reset, active low
//  icache_miss       in   1       level; held until icache_fill_done
//  icache_miss_addr  in   ADDR_W  byte address of missing fetch
//  dcache_miss       in   1       level; held until dcache_fill_done
//  dcache_miss_addr  in   ADDR_W  byte address of missing access
//  dcache_wr         in   1       level; store to write through, held until wr_ack
//  dcache_wr_addr    in   ADDR_W  store byte address
//  dcache_wr_data    in   DATA_W  store data
//  mem_en            out  1       memory access this cycle
//  mem_wr            out  1       1 = write, 0 = read (valid when mem_en)
//  mem_addr          out  ADDR_W  memory byte address
//  mem_data_in       out  DATA_W  write data to memory
//  mem_data_out      in   DATA_W  read data from memory
//  mem_data_valid    in   1       mem_data_out valid this cycle
//  fill_data         out  DATA_W  word being written into a cache
//  fill_word_idx     out  log2(WORDS)  word offset within block of fill_data
//  icache_fill_we    out  1       write fill_data into I-cache
//  dcache_fill_we    out  1       write fill_data into D-cache
//  icache_fill_done  out  1       1-cycle pulse: I block complete, tag may be set valid
//  dcache_fill_done  out  1       1-cycle pulse: D block complete
//  wr_ack            out  1       1-cycle pulse: store accepted by memory
//  cache_stall       out  1       any request pending or FSM not IDLE
// BEHAVIOUR
//  Reset: state IDLE, counters 0; every output 0 (mem_addr, mem_data_in, fill_data = 0).
//  FSM: IDLE -> WRITE | ISSUE; WRITE -> IDLE; ISSUE -> DRAIN; DRAIN -> DONE; DONE -> IDLE.
//  IDLE priority on the same cycle: dcache_miss > dcache_wr > icache_miss. Winner and base address are latched.
//   base = miss_addr & ~(2*WORDS-1).
//  WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_data_in=dcache_wr_data; wr_ack=1.
//  ISSUE: WORDS cycles, mem_en=1, mem_wr=0, mem_addr=base+2*k, k=0..WORDS-1. Issue counter wraps to 0 on exit.
//  DRAIN: no issues; stay until return counter == WORDS.
//   Returns are also counted while still in ISSUE (MEM_LAT < WORDS overlaps).
//  Each mem_data_valid in ISSUE/DRAIN: fill_data=mem_data_out, fill_word_idx=return count.
//   Raise fill_we of the latched requester only (same cycle, combinational), then increment the return count.
//  DONE (1 cycle): fill_done pulse for latched requester; counters cleared.
//  Latency with MEM_LAT=4, WORDS=8 (miss seen in IDLE at cycle 0): issues cycles 1-8, returns 5-12, done 13.
//   Next request is accepted in IDLE at cycle 14.
//  mem_data_valid in IDLE/WRITE/DONE: ignored, no fill_we.
//  Requests arriving while busy: not accepted; callers hold them. They are re-arbitrated on return to IDLE.
//   A D miss that arrives during an I fill is served next, ahead of a still-pending I request.
//  cache_stall = (state!=IDLE) | icache_miss | dcache_miss | dcache_wr. Combinational, 1 in the request cycle.
//  Reset mid-fill: immediate IDLE, no done pulse. Returns still in flight arrive in IDLE and are dropped.
//  Address arithmetic is modulo 2^ADDR_W. A block is aligned, so base+2*k never crosses a block boundary.
// STRUCTURE
//  Shared package: FSM state enum (IDLE, WRITE, ISSUE, DRAIN, DONE), requester enum (REQ_I, REQ_D), WORDS/MEM_LAT defaults.
//  One sub-module, fill_word_counter: a log2(WORDS)+1 bit counter with clear/inc/terminal-count.
//   Instantiated twice, once for issue and once for return. The FSM and steering stay in the top module.
// TESTING
//  1. D miss 0x1234, mem model LAT=4 returning addr^16'hA5A5
//     -> mem_addr 0x1230..0x123E cycles 1-8; 8 dcache_fill_we, idx 0-7; dcache_fill_done at cycle 13.
//  2. icache_miss 0x0040 and dcache_miss 0x2000 in the same cycle
//     -> D block served first (0x2000..0x200E); I block (0x0040..0x004E) starts cycle 14; no icache_fill_we during D fill.
//  3. dcache_wr addr 0x3002 data 0xBEEF with icache_miss pending
//     -> one write cycle (mem_wr=1, 0x3002/0xBEEF), wr_ack pulse, then the I fill.
//  4. rst_n low at cycle 6 of a D fill, released at cycle 8
//     -> all outputs 0, no fill_done; late mem_data_valid causes no fill_we; new miss starts a clean fill at 0 idx.
//  5. Stray mem_data_valid in IDLE with no requests -> no fill_we, cache_stall=0.
//  6. Back-to-back D misses 0xFFF8 then 0x0010 -> first base 0xFFF0 (words 0xFFF0..0xFFFE), second 0x0010, both complete with idx 0-7.

Source files
------------

// File: rtl/mem_fill_arbiter_pkg.sv
// Shared types for the cache fill arbiter: FSM states, requester identity and
// default block geometry / memory latency.
package mem_fill_arbiter_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, DRAIN, DONE} state_e;
  typedef enum logic {REQ_I, REQ_D} req_e;

  localparam int DEF_WORDS   = 8;
  localparam int DEF_MEM_LAT = 4;

endpackage

// File: rtl/mem_fill_arbiter_fill_word_counter.sv
// Word counter for a block refill: sync clear beats increment; o_tc flags the
// increment that completes the block (count WORDS-1 -> WORDS).
module fill_word_counter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_inc,
  output logic [$clog2(WORDS):0] o_cnt,
  output logic                   o_tc
);

  localparam int            CW   = $clog2(WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I/D cache misses and D write-through stores onto a pipelined memory,
// refilling a whole block per miss and steering returned words to the requester.
module mem_fill_arbiter
  import mem_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = DEF_WORDS,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icache_miss,
  input  logic [ADDR_W-1:0]        icache_miss_addr,
  input  logic                     dcache_miss,
  input  logic [ADDR_W-1:0]        dcache_miss_addr,
  input  logic                     dcache_wr,
  input  logic [ADDR_W-1:0]        dcache_wr_addr,
  input  logic [DATA_W-1:0]        dcache_wr_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data_in,
  input  logic [DATA_W-1:0]        mem_data_out,
  input  logic                     mem_data_valid,
  output logic [DATA_W-1:0]        fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word_idx,
  output logic                     icache_fill_we,
  output logic                     dcache_fill_we,
  output logic                     icache_fill_done,
  output logic                     dcache_fill_done,
  output logic                     wr_ack,
  output logic                     cache_stall
);

  localparam int                IW       = $clog2(WORDS);
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS - 1);

  // Returns must arrive strictly after their issue for the drain logic to hold.
  if (MEM_LAT < 1) begin : g_lat_chk
    $error("mem_fill_arbiter: MEM_LAT must be at least 1");
  end

  state_e            r_state;
  req_e              r_req;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic [IW:0] w_iss_cnt, w_ret_cnt;
  logic        w_iss_tc, w_ret_tc;
  logic        w_fill;

  assign w_fill = mem_data_valid && (r_state == ISSUE || r_state == DRAIN);

  fill_word_counter #(.WORDS(WORDS)) u_iss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_iss_tc),
    .i_inc (r_state == ISSUE),
    .o_cnt (w_iss_cnt),
    .o_tc  (w_iss_tc)
  );

  fill_word_counter #(.WORDS(WORDS)) u_ret_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (r_state == DONE),
    .i_inc (w_fill),
    .o_cnt (w_ret_cnt),
    .o_tc  (w_ret_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_req     <= REQ_I;
      r_base    <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dcache_miss) begin
            r_req   <= REQ_D;
            r_base  <= dcache_miss_addr & ~BLK_MASK;
            r_state <= ISSUE;
          end else if (dcache_wr) begin
            r_wr_addr <= dcache_wr_addr;
            r_wr_data <= dcache_wr_data;
            r_state   <= WRITE;
          end else if (icache_miss) begin
            r_req   <= REQ_I;
            r_base  <= icache_miss_addr & ~BLK_MASK;
            r_state <= ISSUE;
          end
        end
        WRITE: r_state <= IDLE;
        ISSUE: if (w_iss_tc) r_state <= DRAIN;
        // Leave on the cycle the last word lands so DONE follows it directly.
        DRAIN: if (w_ret_tc || w_ret_cnt[IW]) r_state <= DONE;
        DONE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en           = (r_state == ISSUE) || (r_state == WRITE);
    mem_wr           = (r_state == WRITE);
    mem_addr         = '0;
    mem_data_in      = '0;
    if (r_state == WRITE) begin
      mem_addr    = r_wr_addr;
      mem_data_in = r_wr_data;
    end else if (r_state == ISSUE) begin
      mem_addr    = r_base + (ADDR_W'(w_iss_cnt) << 1);
    end
    fill_data        = w_fill ? mem_data_out : '0;
    fill_word_idx    = w_fill ? w_ret_cnt[IW-1:0] : '0;
    icache_fill_we   = w_fill && (r_req == REQ_I);
    dcache_fill_we   = w_fill && (r_req == REQ_D);
    icache_fill_done = (r_state == DONE) && (r_req == REQ_I);
    dcache_fill_done = (r_state == DONE) && (r_req == REQ_D);
    wr_ack           = (r_state == WRITE);
    cache_stall      = (r_state != IDLE) || icache_miss || dcache_miss || dcache_wr;
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: transaction-timeline reference model, pipelined
// memory model returning addr^A5A5, directed scenarios then random traffic.
module tb_mem_fill_arbiter;

  localparam int AW = 16, DW = 16, W = 8, LAT = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          icache_miss, dcache_miss, dcache_wr;
  logic [AW-1:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr;
  logic [DW-1:0] dcache_wr_data, mem_data_out;
  logic          mem_data_valid;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, fill_data;
  logic [2:0]    fill_word_idx;
  logic          icache_fill_we, dcache_fill_we, icache_fill_done, dcache_fill_done;
  logic          wr_ack, cache_stall;

  always #5 clk = ~clk;

  mem_fill_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WORDS(W), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_miss(icache_miss), .icache_miss_addr(icache_miss_addr),
    .dcache_miss(dcache_miss), .dcache_miss_addr(dcache_miss_addr),
    .dcache_wr(dcache_wr), .dcache_wr_addr(dcache_wr_addr), .dcache_wr_data(dcache_wr_data),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .fill_data(fill_data), .fill_word_idx(fill_word_idx),
    .icache_fill_we(icache_fill_we), .dcache_fill_we(dcache_fill_we),
    .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
    .wr_ack(wr_ack), .cache_stall(cache_stall)
  );

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: one transaction at a time, described by its start cycle.
  typedef enum {K_NONE, K_WR, K_FI, K_FD} kind_t;
  kind_t         m_kind = K_NONE;
  int            m_s, m_ret;
  logic [AW-1:0] m_base, m_wa;
  logic [DW-1:0] m_wd;
  bit            drop_i, drop_d, drop_w, rnd_on;
  int            stray_pct = 0;

  typedef struct {int due; logic [DW-1:0] d;} ret_t;
  ret_t q[$];

  int n_iwe, n_dwe, n_ack, n_idone, n_ddone, ddone_c, idone_c, ack_c, first_c, n_done_all;
  logic [AW-1:0] first_addr, last_addr, wa_seen;
  logic [DW-1:0] wd_seen;
  bit got_first;

  task automatic clr_mon();
    n_iwe = 0; n_dwe = 0; n_ack = 0; n_idone = 0; n_ddone = 0;
    ddone_c = -1000; idone_c = -1000; ack_c = -1000; first_c = -1000;
    got_first = 0; first_addr = '0; last_addr = '0; wa_seen = '0; wd_seen = '0;
  endtask

  task automatic model_check();
    logic e_en, e_wr, e_iwe, e_dwe, e_idn, e_ddn, e_ack, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_fd;
    logic [2:0] e_idx;
    bit fin;
    int k;
    {e_en, e_wr, e_iwe, e_dwe, e_idn, e_ddn, e_ack} = '0;
    e_addr = '0; e_din = '0; e_fd = '0; e_idx = '0; fin = 0;
    e_stall = icache_miss | dcache_miss | dcache_wr | (m_kind != K_NONE);
    case (m_kind)
      K_WR: begin
        e_en = 1; e_wr = 1; e_addr = m_wa; e_din = m_wd; e_ack = 1; fin = 1; drop_w = 1;
      end
      K_FI, K_FD: begin
        k = cyc - m_s;
        if (k >= 1 && k <= W) begin e_en = 1; e_addr = m_base + 16'(2 * (k - 1)); end
        if (k >= 1 && k <= W + LAT && mem_data_valid) begin
          if (m_kind == K_FI) e_iwe = 1; else e_dwe = 1;
          e_fd  = (m_base + 16'(2 * m_ret)) ^ 16'hA5A5;
          e_idx = 3'(m_ret);
          m_ret++;
        end
        if (k == W + LAT + 1) begin
          if (m_kind == K_FI) begin e_idn = 1; drop_i = 1; end
          else begin e_ddn = 1; drop_d = 1; end
          chk("ret_count", m_ret, W);
          fin = 1;
        end
      end
      default: ;
    endcase
    chk("mem_en", mem_en, e_en);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_data_in", mem_data_in, e_din);
    chk("fill_data", fill_data, e_fd);
    chk("fill_word_idx", fill_word_idx, e_idx);
    chk("icache_fill_we", icache_fill_we, e_iwe);
    chk("dcache_fill_we", dcache_fill_we, e_dwe);
    chk("icache_fill_done", icache_fill_done, e_idn);
    chk("dcache_fill_done", dcache_fill_done, e_ddn);
    chk("wr_ack", wr_ack, e_ack);
    chk("cache_stall", cache_stall, e_stall);
    if (icache_fill_we) n_iwe++;
    if (dcache_fill_we) n_dwe++;
    if (icache_fill_done) begin n_idone++; idone_c = cyc; n_done_all++; end
    if (dcache_fill_done) begin n_ddone++; ddone_c = cyc; n_done_all++; end
    if (wr_ack) begin n_ack++; ack_c = cyc; end
    if (mem_en && mem_wr) begin wa_seen = mem_addr; wd_seen = mem_data_in; end
    if (mem_en && !mem_wr) begin
      if (!got_first) begin got_first = 1; first_addr = mem_addr; first_c = cyc; end
      last_addr = mem_addr;
      q.push_back('{cyc + LAT, mem_addr ^ 16'hA5A5});
    end
    if (fin) m_kind = K_NONE;
    else if (m_kind == K_NONE && rst_n) begin
      if (dcache_miss) begin
        m_kind = K_FD; m_base = dcache_miss_addr & ~16'(2 * W - 1); m_s = cyc; m_ret = 0;
      end else if (dcache_wr) begin
        m_kind = K_WR; m_wa = dcache_wr_addr; m_wd = dcache_wr_data; m_s = cyc;
      end else if (icache_miss) begin
        m_kind = K_FI; m_base = icache_miss_addr & ~16'(2 * W - 1); m_s = cyc; m_ret = 0;
      end
    end
  endtask

  function automatic bit stray_ok();
    return (m_kind == K_NONE) || (m_kind == K_WR) || ((cyc - m_s) > W + LAT) || ((cyc - m_s) < 1);
  endfunction

  task automatic drive();
    if (drop_i) begin icache_miss = 0; drop_i = 0; end
    if (drop_d) begin dcache_miss = 0; drop_d = 0; end
    if (drop_w) begin dcache_wr = 0; drop_w = 0; end
    mem_data_out   = 16'($urandom);
    mem_data_valid = 0;
    if (q.size() > 0 && q[0].due <= cyc) begin
      mem_data_valid = 1; mem_data_out = q[0].d; void'(q.pop_front());
    end else if (stray_pct > 0 && stray_ok() && $urandom_range(99) < stray_pct) begin
      mem_data_valid = 1;
    end
    if (rnd_on) begin
      if (!icache_miss && $urandom_range(9) == 0) begin
        icache_miss = 1; icache_miss_addr = 16'($urandom);
      end
      if (!dcache_miss && $urandom_range(9) == 0) begin
        dcache_miss = 1; dcache_miss_addr = 16'($urandom);
      end
      if (!dcache_wr && $urandom_range(7) == 0) begin
        dcache_wr = 1; dcache_wr_addr = 16'($urandom); dcache_wr_data = 16'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((m_kind != K_NONE || icache_miss || dcache_miss || dcache_wr || q.size() > 0) && n < max) begin
      step();
      n++;
    end
    chk("idle_timeout", n < max, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int t0;

  initial begin
    icache_miss = 0; dcache_miss = 0; dcache_wr = 0;
    icache_miss_addr = '0; dcache_miss_addr = '0; dcache_wr_addr = '0; dcache_wr_data = '0;
    mem_data_out = '0; mem_data_valid = 0;
    n_done_all = 0;
    clr_mon();
    repeat (3) step();
    chk("rst_stall", cache_stall, 1'b0);
    rst_n = 1;
    step();

    // 1: single D miss, exact latency
    clr_mon(); t0 = cyc;
    dcache_miss_addr = 16'h1234; dcache_miss = 1;
    repeat (15) step();
    chk("t1_first_addr", first_addr, 16'h1230);
    chk("t1_first_cyc", first_c - t0, 1);
    chk("t1_last_addr", last_addr, 16'h123E);
    chk("t1_dwe", n_dwe, 8);
    chk("t1_done_cyc", ddone_c - t0, 13);
    wait_idle(50);

    // 2: simultaneous I and D miss, D first
    clr_mon(); t0 = cyc;
    icache_miss_addr = 16'h0040; icache_miss = 1;
    dcache_miss_addr = 16'h2000; dcache_miss = 1;
    repeat (14) step();
    chk("t2_iwe_in_d", n_iwe, 0);
    chk("t2_dwe", n_dwe, 8);
    chk("t2_ddone_cyc", ddone_c - t0, 13);
    repeat (14) step();
    chk("t2_iwe", n_iwe, 8);
    chk("t2_last_addr", last_addr, 16'h004E);
    chk("t2_idone_cyc", idone_c - t0, 27);
    wait_idle(50);

    // 3: store beats pending I miss
    clr_mon(); t0 = cyc;
    icache_miss_addr = 16'h0100; icache_miss = 1;
    dcache_wr_addr = 16'h3002; dcache_wr_data = 16'hBEEF; dcache_wr = 1;
    repeat (16) step();
    chk("t3_ack_cyc", ack_c - t0, 1);
    chk("t3_nack", n_ack, 1);
    chk("t3_waddr", wa_seen, 16'h3002);
    chk("t3_wdata", wd_seen, 16'hBEEF);
    chk("t3_idone_cyc", idone_c - t0, 15);
    wait_idle(50);

    // 4: reset in the middle of a D fill
    clr_mon(); t0 = cyc;
    dcache_miss_addr = 16'($urandom); dcache_miss = 1;
    repeat (6) step();
    rst_n = 0; icache_miss = 0; dcache_miss = 0; dcache_wr = 0;
    drop_i = 0; drop_d = 0; drop_w = 0; m_kind = K_NONE; m_ret = 0;
    repeat (2) step();
    rst_n = 1;
    repeat (6) step();
    chk("t4_no_done", n_ddone, 0);
    chk("t4_dwe_before_rst", n_dwe, 1);
    chk("t4_queue_drained", q.size(), 0);
    clr_mon(); t0 = cyc;
    dcache_miss_addr = 16'h4444; dcache_miss = 1;
    repeat (15) step();
    chk("t4_refill_dwe", n_dwe, 8);
    chk("t4_refill_first", first_addr, 16'h4440);
    chk("t4_refill_done", ddone_c - t0, 13);
    wait_idle(50);

    // 5: stray returns while idle
    clr_mon(); stray_pct = 100;
    repeat (10) step();
    stray_pct = 0;
    chk("t5_no_we", n_iwe + n_dwe, 0);
    chk("t5_stall", cache_stall, 1'b0);

    // 6: back-to-back D misses across the top of the address space
    clr_mon(); t0 = cyc;
    dcache_miss_addr = 16'hFFF8; dcache_miss = 1;
    repeat (15) step();
    chk("t6a_first", first_addr, 16'hFFF0);
    chk("t6a_last", last_addr, 16'hFFFE);
    chk("t6a_dwe", n_dwe, 8);
    clr_mon(); t0 = cyc;
    dcache_miss_addr = 16'h0010; dcache_miss = 1;
    repeat (15) step();
    chk("t6b_first", first_addr, 16'h0010);
    chk("t6b_dwe", n_dwe, 8);
    chk("t6b_done_cyc", ddone_c - t0, 13);
    wait_idle(50);

    // random mixed traffic with stray returns
    n_done_all = 0;
    stray_pct = 25; rnd_on = 1;
    repeat (3000) step();
    rnd_on = 0;
    wait_idle(300);
    chk("rnd_activity", n_done_all > 20, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
